// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging NREQ register-file write requesters onto one write port, with a pending-write (busy) bitmap.
// Latency: grant is combinational; the winner's write appears on wr_* one cycle after the transfer.
// Backpressure: the write port never stalls; exactly one valid requester is granted per cycle, none while in reset.
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rstd,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_data,
  output logic [1:0]           grant_id,
  output logic [(1<<AW)-1:0]   busy
);

  logic [1:0]          r_last;
  logic                r_wr_en;
  logic [AW-1:0]       r_wr_addr;
  logic [DW-1:0]       r_wr_data;
  logic [1:0]          r_grant_id;
  logic [(1<<AW)-1:0]  r_busy;

  logic [1:0]          w_ord [NREQ];
  logic                w_found;
  logic [1:0]          w_win;
  logic [AW-1:0]       w_addr;
  logic [DW-1:0]       w_data;
  logic                w_commit;
  logic [(1<<AW)-1:0]  w_busy_nxt;

  // Search order starts just after the last winner and wraps around.
  always_comb begin
    case (r_last)
      2'd0:    begin w_ord[0] = 2'd1; w_ord[1] = 2'd2; w_ord[2] = 2'd0; end
      2'd1:    begin w_ord[0] = 2'd2; w_ord[1] = 2'd0; w_ord[2] = 2'd1; end
      default: begin w_ord[0] = 2'd0; w_ord[1] = 2'd1; w_ord[2] = 2'd2; end
    endcase
  end

  // Pick the first valid requester in search order; nothing is granted during reset.
  always_comb begin
    w_found   = 1'b0;
    w_win     = 2'd0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[w_ord[k]]) begin
        w_found = 1'b1;
        w_win   = w_ord[k];
      end
    end
    if (rstd) begin
      w_found = 1'b0;
    end
    if (w_found) begin
      req_ready[w_win] = 1'b1;
    end
  end

  // Mux the winner's address and data onto the write path.
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == 2'(i)) begin
        w_addr = req_addr[i*AW +: AW];
        w_data = req_data[i*DW +: DW];
      end
    end
    w_commit = w_found && (w_addr != '0);
  end

  // Busy bitmap: a reservation set beats a same-address clear; r0 is never busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_commit) begin
      w_busy_nxt[w_addr] = 1'b0;
    end
    if (rsv_valid && (rsv_addr != '0)) begin
      w_busy_nxt[rsv_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Register the pointer, the write port and the busy bitmap; r0 writes are acked but not committed.
  always_ff @(posedge clk) begin
    if (rstd) begin
      r_last     <= 2'd2;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_grant_id <= 2'd0;
      r_busy     <= '0;
    end else begin
      if (w_found) begin
        r_last <= w_win;
      end
      r_wr_en <= w_commit;
      if (w_commit) begin
        r_wr_addr  <= w_addr;
        r_wr_data  <= w_data;
        r_grant_id <= w_win;
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL use these parameters, fixed at the listed defaults: NREQ, 3, number of write requesters; AW, 5, register address width; DW, 32, register data width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstd, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port req_valid, input, 3, per-requester write request.
REQ-005 The block SHALL have port req_ready, output, 3, per-requester grant, combinational.
REQ-006 The block SHALL have port req_addr, input, 15, requester i address at bits [5i+4:5i].
REQ-007 The block SHALL have port req_data, input, 96, requester i data at bits [32i+31:32i].
REQ-008 The block SHALL have port rsv_valid, input, 1, issue-stage destination reservation strobe.
REQ-009 The block SHALL have port rsv_addr, input, 5, register being reserved.
REQ-010 The block SHALL have port wr_en, output, 1, registered register-file write enable.
REQ-011 The block SHALL have port wr_addr, output, 5, registered register-file write address.
REQ-012 The block SHALL have port wr_data, output, 32, registered register-file write data.
REQ-013 The block SHALL have port grant_id, output, 2, registered index of the requester driving wr_*.
REQ-014 The block SHALL have port busy, output, 32, registered pending-write bitmap, one bit per register.

Function
REQ-015 Transfer: requester i transfers in any cycle where req_valid[i]=1 and req_ready[i]=1; a requester holds valid, addr and data stable until it transfers.
REQ-016 Grant count: at most one req_ready bit is 1 per cycle, and it is 1 only for a requester with valid=1; with no valid requester, req_ready=000.
REQ-017 Round-robin: 2-bit pointer last (0..2); search order last+1, last+2, last+3, each taken mod 3; the first valid requester in that order wins.
REQ-018 Pointer update: last is loaded with the winner index on a transfer edge, otherwise it holds.
REQ-019 Throughput: the write port never stalls, so a continuously valid set of requesters is served one transfer per cycle with no bubbles.
REQ-020 Latency: a transfer in cycle N drives wr_addr, wr_data and grant_id from the winner in cycle N+1; the register file commits at the end of cycle N+1.
REQ-021 Write enable: wr_en=1 in cycle N+1 iff a transfer occurred in cycle N with addr!=0; otherwise wr_en=0.
REQ-022 Writes to r0 are acknowledged (ready=1, pointer advances) but suppressed (wr_en=0).
REQ-023 Hold: when wr_en=0, wr_addr, wr_data and grant_id hold their previous values.
REQ-024 Reservation: rsv_valid=1 with rsv_addr!=0 sets busy[rsv_addr] at the edge.
REQ-025 Reservations to r0 are ignored; busy[0] is always 0.
REQ-026 Busy clear: a transfer with addr a != 0 clears busy[a] at the same edge that loads wr_*.
REQ-027 Simultaneous set and clear of the same address at one edge: set wins and busy stays 1.
REQ-028 Simultaneous set and clear of different addresses at one edge: both take effect.
REQ-029 A transfer to a register whose busy bit is 0 is legal; the write proceeds and busy stays 0.

Reset
REQ-030 While rstd=1 at an edge: wr_en=0, wr_addr=0, wr_data=0, grant_id=0, busy=0, last=2.
REQ-031 While rstd=1: req_ready=000, so no transfer occurs.
REQ-032 While rstd=1: reservations are discarded.
REQ-033 Reset mid-operation discards any in-flight grant; the first cycle after reset deasserts arbitrates with requester 0 highest.

Verification
REQ-034 Scenario: after reset, req_valid=111 held for 6 cycles -> grants 0,1,2,0,1,2; wr_en=1 on every cycle from cycle 2; grant_id follows one cycle later.
REQ-035 Scenario: rsv_addr=7 in cycle 1, then requester 1 writes addr 7, data 0xDEADBEEF in cycle 3 -> busy[7]=1 from cycle 2 until the cycle-3 edge; wr_en=1, wr_addr=7, wr_data=0xDEADBEEF in cycle 4.
REQ-036 Scenario: requester 2 writes addr 0, data 0x12345678 -> req_ready[2]=1, next cycle wr_en=0, busy unchanged, last=2.
REQ-037 Scenario: reservation and transfer on addr 9 in the same cycle with busy[9]=1 -> busy[9] remains 1 after the edge.
REQ-038 Scenario: rstd=1 asserted in the cycle after requester 0 is granted -> wr_en=0 and busy=0 after the edge; next grant goes to requester 0 when valid=111.
